// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Iterative restoring divider beside a latency-parametrised multiplier.
module muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_code,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   rsv_q, rsv_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              dz_q, dz_d;
  logic              done_q, done_d;

  logic              accept;
  logic              mul_fin;
  logic              fix_fin;
  logic              is_mul;
  logic              is_div;
  logic              is_mthi;
  logic              is_mtlo;
  logic              sgn;
  logic              a_neg;
  logic              b_neg;
  logic [2*XLEN-1:0] ext_a;
  logic [2*XLEN-1:0] ext_b;
  logic [XLEN:0]     part;
  logic              ge;
  logic [XLEN-1:0]   sub;

  assign is_mul  = op_code[2:1] == 2'b00;
  assign is_div  = op_code[2:1] == 2'b01;
  assign is_mthi = op_code == 3'd4;
  assign is_mtlo = op_code == 3'd5;
  assign sgn     = ~op_code[0];
  assign a_neg   = sgn & rs_val[XLEN-1];
  assign b_neg   = sgn & rt_val[XLEN-1];

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept && is_mul) state_d = S_MUL;
          if (accept && is_div) state_d = S_DIV;
        end
        S_MUL:   if (cnt_q == '0) state_d = S_IDLE;
        S_DIV:   if (cnt_q == '0) state_d = S_FIX;
        S_FIX:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = state_q != S_IDLE;
    op_ready = ~busy;
    accept   = op_valid & op_ready & ~flush;
    mul_fin  = (state_q == S_MUL) & (cnt_q == '0) & ~flush;
    fix_fin  = (state_q == S_FIX) & ~flush;
  end

  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    prod_d = prod_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    rsv_d  = rsv_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    done_d = 1'b0;
    ext_a  = {{XLEN{a_neg}}, rs_val};
    ext_b  = {{XLEN{b_neg}}, rt_val};
    // one restoring step: shift in next dividend bit, subtract if it fits
    part   = {rem_q, quo_q[XLEN-1]};
    ge     = part >= {1'b0, dvs_q};
    sub    = part[XLEN-1:0] - dvs_q;

    if (accept) begin
      unique case (1'b1)
        is_mul: begin
          prod_d = ext_a * ext_b;
          cnt_d  = CW'(MUL_LAT - 1);
        end
        is_div: begin
          quo_d  = a_neg ? -rs_val : rs_val;
          dvs_d  = b_neg ? -rt_val : rt_val;
          rem_d  = '0;
          rsv_d  = rs_val;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          dz_d   = rt_val == '0;
          cnt_d  = CW'(XLEN - 1);
        end
        is_mthi: hi_d = rs_val;
        is_mtlo: lo_d = rs_val;
        default: ;
      endcase
    end

    if (state_q == S_MUL && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (state_q == S_DIV) begin
      cnt_d = cnt_q - 1'b1;
      rem_d = ge ? sub : part[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], ge};
    end

    if (mul_fin) begin
      hi_d   = prod_q[2*XLEN-1:XLEN];
      lo_d   = prod_q[XLEN-1:0];
      done_d = 1'b1;
    end

    if (fix_fin) begin
      if (dz_q) begin
        lo_d = '1;
        hi_d = rsv_q;
      end else begin
        lo_d = qneg_q ? -quo_q : quo_q;
        hi_d = rneg_q ? -rem_q : rem_q;
      end
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      prod_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      rsv_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      prod_q <= prod_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      rsv_q  <= rsv_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit/lat-4 instance and a
// 16-bit/lat-1 instance, checked against a plain-arithmetic model.
module tb_muldiv_unit;

  localparam int MUL_LAT = 4;

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_code = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        v2 = 1'b0;
  logic        rdy2;
  logic [2:0]  code2 = '0;
  logic [15:0] a2 = '0;
  logic [15:0] b2 = '0;
  logic        flush2 = 1'b0;
  logic        busy2;
  logic        done2;
  logic [15:0] hi2;
  logic [15:0] lo2;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        q1[$];
  exp_t        q2[$];
  exp_t        e1;
  exp_t        e2;
  logic [31:0] mhi[2];
  logic [31:0] mlo[2];

  muldiv_unit #(.XLEN(32), .MUL_LAT(MUL_LAT)) u_dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  muldiv_unit #(.XLEN(16), .MUL_LAT(1)) u_dut16 (
    .clk(clk), .reset(reset),
    .op_valid(v2), .op_ready(rdy2),
    .op_code(code2), .rs_val(a2), .rt_val(b2),
    .flush(flush2), .busy(busy2), .done(done2),
    .hi(hi2), .lo(lo2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // MIPS-style HI/LO semantics from signed/unsigned 64-bit arithmetic
  function automatic void ref_op(input int w, input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 inout logic [31:0] h,
                                 inout logic [31:0] l);
    longint unsigned mask, ua, ub, pu;
    longint sa, sb, ps, sm;
    mask = (64'd1 << w) - 64'd1;
    sm   = longint'(mask);
    ua   = {32'h0, a} & mask;
    ub   = {32'h0, b} & mask;
    sa   = longint'(ua);
    sb   = longint'(ub);
    if (ua[w-1]) sa = sa - (longint'(1) << w);
    if (ub[w-1]) sb = sb - (longint'(1) << w);
    case (op)
      3'd0: begin
        ps = sa * sb;
        h  = 32'((ps >>> w) & sm);
        l  = 32'(ps & sm);
      end
      3'd1: begin
        pu = ua * ub;
        h  = 32'((pu >> w) & mask);
        l  = 32'(pu & mask);
      end
      3'd2, 3'd3: begin
        if (ub == 0) begin
          l = 32'(mask);
          h = 32'(ua);
        end else if (op == 3'd2) begin
          l = 32'((sa / sb) & sm);
          h = 32'((sa % sb) & sm);
        end else begin
          l = 32'(ua / ub);
          h = 32'(ua % ub);
        end
      end
      3'd4: h = 32'(ua);
      3'd5: l = 32'(ua);
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return m;
      2: return 32'h1 << (w - 1);
      3: return 32'h1;
      4: return 32'($urandom_range(0, 9));
      default: return $urandom() & m;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done32 actual=1 expected=0");
      end else begin
        e1 = q1.pop_front();
        chk("hi32", hi, e1.h);
        chk("lo32", lo, e1.l);
        chk("done_cycle32", 32'(cyc), 32'(e1.c));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done2) begin
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done16 actual=1 expected=0");
      end else begin
        e2 = q2.pop_front();
        chk("hi16", {16'h0, hi2}, e2.h);
        chk("lo16", {16'h0, lo2}, e2.l);
        chk("done_cycle16", 32'(cyc), 32'(e2.c));
      end
    end
  end

  task automatic issue(input bit d2, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit exp_done, output int acc);
    int w;
    int n;
    logic [31:0] h;
    logic [31:0] l;
    exp_t e;
    w = d2 ? 16 : 32;
    n = 0;
    @(negedge clk);
    while ((d2 ? busy2 : busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL issue_wait actual=busy expected=idle");
    end
    if (d2) begin
      v2 = 1'b1; code2 = op; a2 = a[15:0]; b2 = b[15:0];
    end else begin
      op_valid = 1'b1; op_code = op; rs_val = a; rt_val = b;
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    v2 = 1'b0;
    rs_val = $urandom();
    rt_val = $urandom();
    acc = cyc;
    h = mhi[d2];
    l = mlo[d2];
    ref_op(w, op, a, b, h, l);
    if (op <= 3'd3) begin
      if (exp_done) begin
        e.h = h;
        e.l = l;
        e.c = acc + (op[1] ? w + 1 : (d2 ? 1 : MUL_LAT));
        if (d2) q2.push_back(e);
        else    q1.push_back(e);
        mhi[d2] = h;
        mlo[d2] = l;
      end
    end else begin
      mhi[d2] = h;
      mlo[d2] = l;
      @(negedge clk);
      if (d2) begin
        chk("mt_hi16", {16'h0, hi2}, h);
        chk("mt_lo16", {16'h0, lo2}, l);
        chk("mt_busy16", {31'h0, busy2}, 32'h0);
      end else begin
        chk("mt_hi32", hi, h);
        chk("mt_lo32", lo, l);
        chk("mt_busy32", {31'h0, busy}, 32'h0);
      end
    end
  endtask

  initial begin
    int acc;
    int acc2;
    int n;
    logic [2:0] op;
    mhi[0] = '0; mlo[0] = '0;
    mhi[1] = '0; mlo[1] = '0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_hi16", {16'h0, hi2}, 32'h0);

    issue(0, 3'd0, 32'hFFFF_FFFE, 32'h3, 1, acc);
    chk("mul_busy", {31'h0, busy}, 32'h1);
    issue(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, acc);
    issue(0, 3'd2, 32'hFFFF_FFF9, 32'h2, 1, acc);
    issue(0, 3'd3, 32'd100, 32'h0, 1, acc);
    issue(0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, acc);

    // flush while dividing: no done, HI untouched
    issue(0, 3'd4, 32'h11, 32'h0, 1, acc);
    issue(0, 3'd3, 32'd50, 32'd7, 0, acc);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy", {31'h0, busy}, 32'h0);
    repeat (40) @(negedge clk);
    chk("flush_hi", hi, 32'h11);

    // flush in idle blocks the accept
    @(negedge clk);
    flush = 1'b1; op_valid = 1'b1;
    op_code = 3'd5; rs_val = 32'hDEAD;
    @(posedge clk);
    #1 flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle_lo", lo, mlo[0]);

    // MTLO held through a busy multiply lands after done
    issue(0, 3'd0, 32'd5, 32'd6, 1, acc);
    op_valid = 1'b1; op_code = 3'd5; rs_val = 32'h1234;
    n = 0;
    @(negedge clk);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("held_done_seen", {31'h0, done}, 32'h1);
    @(posedge clk);
    #1 op_valid = 1'b0;
    mlo[0] = 32'h1234;
    @(negedge clk);
    chk("held_mtlo_lo", lo, 32'h1234);
    chk("held_mtlo_hi", hi, mhi[0]);

    // reset in the middle of a multiply
    issue(0, 3'd0, 32'd7, 32'd9, 0, acc);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    mhi[0] = '0; mlo[0] = '0;
    mhi[1] = '0; mlo[1] = '0;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'h0);
    repeat (8) @(negedge clk);

    // back-to-back multiplies
    issue(0, 3'd0, 32'h1234_5678, 32'hFEDC_BA98, 1, acc);
    issue(0, 3'd1, 32'h8765_4321, 32'h0000_1001, 1, acc2);
    chk("b2b_gap32", 32'(acc2 - acc), 32'(MUL_LAT + 1));

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      issue(0, op, pick(32), pick(32), 1, acc);
    end

    issue(1, 3'd0, 32'hFFFE, 32'h3, 1, acc);
    issue(1, 3'd1, 32'hFFFF, 32'hFFFF, 1, acc);
    issue(1, 3'd2, 32'h8000, 32'hFFFF, 1, acc);
    issue(1, 3'd0, 32'h7FFF, 32'h8000, 1, acc);
    issue(1, 3'd0, 32'h0123, 32'h0456, 1, acc2);
    chk("b2b_gap16", 32'(acc2 - acc), 32'd2);
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      issue(1, op, pick(16), pick(16), 1, acc);
    end

    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q1.size() + q2.size()), 32'h0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
